// File: rtl/sa_out_fifo_bank_if.sv
// Bundle of the flush, push, pop and status signals between the systolic
// array, the output FIFO bank and the data mover.
interface sa_out_fifo_bank_if #(
    parameter int FIFO_DATA_WIDTH = 8,
    parameter int PE_SIZE         = 16
);
    logic                               clr_i;
    logic [PE_SIZE-1:0]                 wen_i;
    logic [FIFO_DATA_WIDTH*PE_SIZE-1:0] wdata_i;
    logic [PE_SIZE-1:0]                 rden_i;
    logic [FIFO_DATA_WIDTH*PE_SIZE-1:0] rdata_o;
    logic [PE_SIZE-1:0]                 full_o;
    logic [PE_SIZE-1:0]                 empty_o;
    logic                               all_empty_o;
    logic                               row_ready_o;
    logic                               ovf_err_o;
    logic                               udf_err_o;

    modport master (
        output clr_i, wen_i, wdata_i, rden_i,
        input  rdata_o, full_o, empty_o, all_empty_o, row_ready_o, ovf_err_o, udf_err_o
    );

    modport slave (
        input  clr_i, wen_i, wdata_i, rden_i,
        output rdata_o, full_o, empty_o, all_empty_o, row_ready_o, ovf_err_o, udf_err_o
    );
endinterface

// File: rtl/sa_out_fifo_bank.sv
// Bank of independent first-word-fall-through FIFOs, one per systolic-array
// column, with sticky overflow/underflow flags and a synchronous flush.
module sa_out_fifo_bank #(
    parameter int FIFO_DATA_WIDTH = 8,
    parameter int PE_SIZE         = 16,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    sa_out_fifo_bank_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int W  = FIFO_DATA_WIDTH;
    localparam int LW = FIFO_DATA_WIDTH * PE_SIZE;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] ROW_CNT   = (AW+1)'(PE_SIZE);

    logic [PE_SIZE-1:0] full;
    logic [PE_SIZE-1:0] empty;
    logic [PE_SIZE-1:0] ovf_hit;
    logic [PE_SIZE-1:0] udf_hit;
    logic [LW-1:0]      rdata;
    logic [AW:0]        lane0_cnt;
    logic               ovf_err;
    logic               udf_err;

    for (genvar i = 0; i < PE_SIZE; i++) begin : g_lane
        logic [W-1:0]  mem [FIFO_DEPTH];
        logic [AW-1:0] wptr;
        logic [AW-1:0] rptr;
        logic [AW:0]   cnt;
        logic [W-1:0]  wslice;
        logic          do_pop;
        logic          do_push;

        assign wslice   = bus.wdata_i[LW-1-i*W -: W];
        assign full[i]  = (cnt == DEPTH_CNT);
        assign empty[i] = (cnt == '0);

        // A full lane can still accept a push when a pop frees a slot on the same edge.
        assign do_pop     = bus.rden_i[i] && !empty[i];
        assign do_push    = bus.wen_i[i] && (!full[i] || do_pop);
        assign ovf_hit[i] = bus.wen_i[i] && full[i] && !do_pop;
        assign udf_hit[i] = bus.rden_i[i] && empty[i];

        assign rdata[LW-1-i*W -: W] = empty[i] ? '0 : mem[rptr];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
            end else if (bus.clr_i) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
            end else begin
                if (do_push) wptr <= wptr + 1'b1;
                if (do_pop)  rptr <= rptr + 1'b1;
                if (do_push && !do_pop)      cnt <= cnt + 1'b1;
                else if (!do_push && do_pop) cnt <= cnt - 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (do_push && !bus.clr_i) mem[wptr] <= wslice;
        end

        if (i == 0) begin : g_lane0
            assign lane0_cnt = cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else if (bus.clr_i) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            ovf_err <= ovf_err || (|ovf_hit);
            udf_err <= udf_err || (|udf_hit);
        end
    end

    assign bus.rdata_o     = rdata;
    assign bus.full_o      = full;
    assign bus.empty_o     = empty;
    assign bus.all_empty_o = &empty;
    assign bus.row_ready_o = (lane0_cnt >= ROW_CNT);
    assign bus.ovf_err_o   = ovf_err;
    assign bus.udf_err_o   = udf_err;
endmodule
